// File: rtl/cnn_frame_sequencer.sv
// ============================================================================
// Module   : cnn_frame_sequencer
// Brief    : Sequences one ap_ctrl_hs CNN inference per cropped frame: gates
//            the pixel stream, drives ap_start, unpacks the 160-bit result.
//            Optional watchdog compiled in with `define CNN_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_frame_sequencer #(
    parameter int OUT_ROWS       = 48,
    parameter int OUT_COLS       = 48,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic         ap_clk,
    input  logic         ap_rst,
    input  logic [7:0]   pix_in_tdata,
    input  logic         pix_in_tvalid,
    output logic         pix_in_tready,
    input  logic         pix_in_tlast,
    output logic         cnn_ap_start,
    input  logic         cnn_ap_ready,
    input  logic         cnn_ap_idle,
    input  logic         cnn_ap_done,
    output logic [7:0]   cnn_in_tdata,
    output logic         cnn_in_tvalid,
    input  logic         cnn_in_tready,
    input  logic [159:0] cnn_out_tdata,
    input  logic         cnn_out_tvalid,
    output logic         cnn_out_tready,
    output logic [109:0] res_tdata,
    output logic         res_tvalid,
    input  logic         res_tready,
    output logic         busy,
    output logic [15:0]  frame_cnt,
    output logic         err_len,
    output logic         timeout
);

    localparam int unsigned       C_PIX_N    = OUT_ROWS * OUT_COLS;
    localparam int                C_CNT_W    = (C_PIX_N > 1) ? $clog2(C_PIX_N + 1) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST_IDX = C_CNT_W'(C_PIX_N - 1);
    localparam logic [31:0]       C_WD_LIMIT = 32'(TIMEOUT_CYCLES);
    localparam int                C_SLOTS    = 5;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_STREAM   = 2'd1,
        S_WAIT_OUT = 2'd2,
        S_DELIVER  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_CNT_W-1:0]   r_pix_cnt;
    logic                 r_start_pend;
    logic [109:0]         r_res;
    logic                 r_res_valid;
    logic [15:0]          r_frame_cnt;
    logic                 r_err_len;

    logic                 w_pix_hs;
    logic                 w_out_hs;
    logic                 w_res_hs;
    logic                 w_last_pix;
    logic                 w_wd_hit;
    logic [109:0]         w_unpack;

    assign w_pix_hs   = (r_state == S_STREAM) && pix_in_tvalid && cnn_in_tready;
    assign w_out_hs   = (r_state == S_WAIT_OUT) && cnn_out_tvalid;
    assign w_res_hs   = (r_state == S_DELIVER) && r_res_valid && res_tready;
    assign w_last_pix = (r_pix_cnt == C_LAST_IDX);

    // Each 32-bit slot carries an ap_fixed<22,11> in its low 22 bits.
    generate
        for (genvar k = 0; k < C_SLOTS; k++) begin : g_unpack
            assign w_unpack[22*k +: 22] = cnn_out_tdata[32*k +: 22];
        end
    endgenerate

    // The discarded upper slot bits and the status-only done strobe are not consumed.
    logic w_unused_inputs;
    assign w_unused_inputs = ^{cnn_ap_done, cnn_out_tdata};

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        pix_in_tready  = 1'b0;
        cnn_in_tvalid  = 1'b0;
        cnn_in_tdata   = 8'd0;
        cnn_ap_start   = 1'b0;
        cnn_out_tready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (pix_in_tvalid && cnn_ap_idle) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                cnn_ap_start  = r_start_pend;
                cnn_in_tdata  = pix_in_tdata;
                cnn_in_tvalid = pix_in_tvalid;
                pix_in_tready = cnn_in_tready;
                if (w_wd_hit) begin
                    w_state_nxt = S_IDLE;
                end else if (w_pix_hs && w_last_pix) begin
                    w_state_nxt = S_WAIT_OUT;
                end
            end
            S_WAIT_OUT: begin
                cnn_out_tready = 1'b1;
                if (w_wd_hit) begin
                    w_state_nxt = S_IDLE;
                end else if (w_out_hs) begin
                    w_state_nxt = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (w_res_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_pix_cnt    <= '0;
            r_start_pend <= 1'b0;
            r_res        <= '0;
            r_res_valid  <= 1'b0;
            r_frame_cnt  <= 16'd0;
            r_err_len    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pix_cnt <= '0;
                    if (pix_in_tvalid && cnn_ap_idle) begin
                        r_start_pend <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (cnn_ap_ready || w_wd_hit) begin
                        r_start_pend <= 1'b0;
                    end
                    if (w_pix_hs) begin
                        r_pix_cnt <= r_pix_cnt + 1'b1;
                        // Only flagged; the pixel count alone decides the frame end.
                        if (pix_in_tlast != w_last_pix) begin
                            r_err_len <= 1'b1;
                        end
                    end
                end
                S_WAIT_OUT: begin
                    if (w_wd_hit) begin
                        r_start_pend <= 1'b0;
                    end else if (w_out_hs) begin
                        r_res       <= w_unpack;
                        r_res_valid <= 1'b1;
                    end
                end
                S_DELIVER: begin
                    if (w_res_hs) begin
                        r_res_valid <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CNN_SEQ_TIMEOUT_EN
    logic [31:0] r_wd_cnt;
    logic        r_timeout;
    logic        w_wd_active;

    assign w_wd_active = (r_state == S_STREAM) || (r_state == S_WAIT_OUT);
    assign w_wd_hit    = w_wd_active && !w_pix_hs && !w_out_hs &&
                         (r_wd_cnt == C_WD_LIMIT - 32'd1);

    // Counts idle cycles since state entry or the last forward progress.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_wd_cnt  <= 32'd0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_wd_active || w_pix_hs || w_out_hs || w_wd_hit) begin
                r_wd_cnt <= 32'd0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 32'd1;
            end
            if (w_wd_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_wd_limit;
    assign w_unused_wd_limit = ^C_WD_LIMIT;
    assign w_wd_hit          = 1'b0;
    assign timeout           = 1'b0;
`endif

    assign res_tdata  = r_res;
    assign res_tvalid = r_res_valid;
    assign busy       = (r_state != S_IDLE);
    assign frame_cnt  = r_frame_cnt;
    assign err_len    = r_err_len;

endmodule

`default_nettype wire

// File: tb/tb_cnn_frame_sequencer.sv
// ============================================================================
// Module   : tb_cnn_frame_sequencer
// Brief    : Randomised frame-level bench with a behavioural CNN/source model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnn_frame_sequencer;

    localparam int N = 48 * 48;

    logic         ap_clk = 1'b0;
    logic         ap_rst = 1'b1;
    logic [7:0]   pix_in_tdata = '0;
    logic         pix_in_tvalid = 1'b0;
    logic         pix_in_tready;
    logic         pix_in_tlast = 1'b0;
    logic         cnn_ap_start;
    logic         cnn_ap_ready = 1'b0;
    logic         cnn_ap_idle = 1'b1;
    logic         cnn_ap_done = 1'b0;
    logic [7:0]   cnn_in_tdata;
    logic         cnn_in_tvalid;
    logic         cnn_in_tready = 1'b0;
    logic [159:0] cnn_out_tdata = '0;
    logic         cnn_out_tvalid = 1'b0;
    logic         cnn_out_tready;
    logic [109:0] res_tdata;
    logic         res_tvalid;
    logic         res_tready = 1'b0;
    logic         busy;
    logic [15:0]  frame_cnt;
    logic         err_len;
    logic         timeout;

    cnn_frame_sequencer #(
        .OUT_ROWS(48), .OUT_COLS(48), .TIMEOUT_CYCLES(100)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .pix_in_tdata(pix_in_tdata), .pix_in_tvalid(pix_in_tvalid),
        .pix_in_tready(pix_in_tready), .pix_in_tlast(pix_in_tlast),
        .cnn_ap_start(cnn_ap_start), .cnn_ap_ready(cnn_ap_ready),
        .cnn_ap_idle(cnn_ap_idle), .cnn_ap_done(cnn_ap_done),
        .cnn_in_tdata(cnn_in_tdata), .cnn_in_tvalid(cnn_in_tvalid),
        .cnn_in_tready(cnn_in_tready),
        .cnn_out_tdata(cnn_out_tdata), .cnn_out_tvalid(cnn_out_tvalid),
        .cnn_out_tready(cnn_out_tready),
        .res_tdata(res_tdata), .res_tvalid(res_tvalid), .res_tready(res_tready),
        .busy(busy), .frame_cnt(frame_cnt), .err_len(err_len), .timeout(timeout)
    );

    always #5 ap_clk = ~ap_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Knobs and upstream source.
    logic [8:0]   q_src[$];
    int           cin_rdy_pct = 100;
    int           res_rdy_pct = 100;
    int           apr_pct     = 30;
    bit           force_busy  = 0;

    // Behavioural CNN model.
    logic [159:0] m_word = '0;
    int           m_lat  = 3;
    int           m_rx   = 0;
    int           m_wait = 0;
    bit           m_busy = 0;
    bit           m_out_pending = 0;
    bit           m_no_out = 0;

    // Frame-level expectations.
    int           fwd_cnt   = 0;
    bit           rdy_seen  = 0;
    bit           out_done  = 0;
    logic [109:0] exp_res   = '0;
    int           exp_frames = 0;
    bit           exp_err   = 0;
    int           q_fwd_per_frame[$];
    logic [109:0] q_res[$];

    function automatic logic [109:0] unpack(input logic [159:0] w);
        logic [109:0] r;
        for (int k = 0; k < 5; k++) begin
            r[22*k +: 22] = w[32*k +: 22];
        end
        return r;
    endfunction

    task automatic load_frame(input int kind);
        logic [7:0] d;
        bit         last;
        for (int i = 0; i < N; i++) begin
            d    = (kind == 1) ? 8'($urandom_range(255)) : 8'(i % 256);
            last = (kind == 2) ? (i == 100) : (i == N - 1);
            q_src.push_back({last, d});
        end
    endtask

    task automatic clear_model();
        q_src.delete();
        fwd_cnt = 0; rdy_seen = 0; out_done = 0;
        exp_frames = 0; exp_err = 0;
        m_rx = 0; m_wait = 0; m_busy = 0; m_out_pending = 0; m_no_out = 0;
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        pix_in_tvalid = 1'b0; cnn_in_tready = 1'b0; res_tready = 1'b0;
        cnn_out_tvalid = 1'b0; cnn_ap_ready = 1'b0; cnn_ap_idle = 1'b1;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        clear_model();
    endtask

    // One clock cycle of source, CNN and sink behaviour plus per-cycle checks.
    task automatic step();
        bit streaming, hs_pix, hs_out, hs_res, smp_rdy, exp_start;
        logic [109:0] res_smp;
        pix_in_tvalid = (q_src.size() > 0);
        {pix_in_tlast, pix_in_tdata} = (q_src.size() > 0) ? q_src[0] : 9'd0;
        cnn_in_tready  = ($urandom_range(99) < cin_rdy_pct);
        res_tready     = ($urandom_range(99) < res_rdy_pct);
        cnn_ap_ready   = ($urandom_range(99) < apr_pct);
        cnn_ap_idle    = !(m_busy || force_busy);
        cnn_out_tvalid = m_out_pending;
        cnn_out_tdata  = m_word;
        #2;
        streaming = busy && (fwd_cnt < N);
        exp_start = streaming && !rdy_seen;
        n_tests += 4;
        if (cnn_ap_start !== exp_start) begin
            n_fail++; $display("FAIL ap_start cyc=%0d got=%b exp=%b", cyc, cnn_ap_start, exp_start);
        end
        if (pix_in_tready !== (streaming && cnn_in_tready)) begin
            n_fail++; $display("FAIL pix_tready cyc=%0d got=%b exp=%b", cyc, pix_in_tready, streaming && cnn_in_tready);
        end
        if (cnn_in_tvalid !== (streaming && pix_in_tvalid)) begin
            n_fail++; $display("FAIL cnn_tvalid cyc=%0d got=%b exp=%b", cyc, cnn_in_tvalid, streaming && pix_in_tvalid);
        end
        if (cnn_out_tready !== (busy && fwd_cnt == N && !out_done)) begin
            n_fail++; $display("FAIL out_tready cyc=%0d got=%b exp=%b", cyc, cnn_out_tready, busy && fwd_cnt == N && !out_done);
        end
        if (streaming) begin
            n_tests++;
            if (cnn_in_tdata !== pix_in_tdata) begin
                n_fail++; $display("FAIL passthru cyc=%0d got=%h exp=%h", cyc, cnn_in_tdata, pix_in_tdata);
            end
        end
        n_tests++;
        if (busy && out_done) begin
            if (res_tvalid !== 1'b1 || res_tdata !== exp_res) begin
                n_fail++; $display("FAIL res_hold cyc=%0d got=%b/%h exp=1/%h", cyc, res_tvalid, res_tdata, exp_res);
            end
        end else if (res_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL res_idle cyc=%0d got=%b exp=0", cyc, res_tvalid);
        end
`ifndef CNN_SEQ_TIMEOUT_EN
        n_tests++;
        if (timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_tied cyc=%0d got=%b exp=0", cyc, timeout);
        end
`endif
        hs_pix  = pix_in_tvalid && pix_in_tready;
        hs_out  = cnn_out_tvalid && cnn_out_tready;
        hs_res  = res_tvalid && res_tready;
        smp_rdy = cnn_ap_ready && streaming;
        res_smp = res_tdata;
        if (hs_pix && (pix_in_tlast != (fwd_cnt == N - 1))) exp_err = 1;

        @(posedge ap_clk); #1;
        cyc++;

        if (smp_rdy) rdy_seen = 1;
        if (hs_pix) begin
            void'(q_src.pop_front());
            fwd_cnt++;
            m_rx++;
            m_busy = 1;
            if (m_rx == N) m_wait = m_lat;
        end else if (m_rx == N && !m_out_pending) begin
            if (m_wait > 0) m_wait--;
            else if (!m_no_out) m_out_pending = 1;
        end
        if (hs_out) begin
            m_out_pending = 0; m_busy = 0; m_rx = 0;
            out_done = 1;
            exp_res  = unpack(m_word);
            n_tests++;
            if (res_tvalid !== 1'b1) begin
                n_fail++; $display("FAIL res_latency cyc=%0d got=%b exp=1", cyc, res_tvalid);
            end
        end
        if (hs_res) begin
            exp_frames++;
            q_fwd_per_frame.push_back(fwd_cnt);
            q_res.push_back(res_smp);
            n_tests++;
            if (busy !== 1'b0) begin
                n_fail++; $display("FAIL busy_fall cyc=%0d got=%b exp=0", cyc, busy);
            end
        end
        if (!busy) begin
            fwd_cnt = 0; rdy_seen = 0; out_done = 0;
        end
        n_tests += 2;
        if (frame_cnt !== 16'(exp_frames)) begin
            n_fail++; $display("FAIL frame_cnt cyc=%0d got=%0d exp=%0d", cyc, frame_cnt, exp_frames);
        end
        if (err_len !== exp_err) begin
            n_fail++; $display("FAIL err_len cyc=%0d got=%b exp=%b", cyc, err_len, exp_err);
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        int c = 0;
        while (exp_frames < target && c < budget) begin
            step();
            c++;
        end
        n_tests++;
        if (exp_frames < target) begin
            n_fail++; $display("FAIL frame_budget got=%0d exp=%0d", exp_frames, target);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({pix_in_tready, cnn_ap_start, cnn_in_tvalid, cnn_in_tdata, cnn_out_tready,
             res_tvalid, busy, err_len, timeout} !== 17'd0 ||
            res_tdata !== 110'd0 || frame_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_outputs busy=%b start=%b res=%h fc=%0d got nonzero exp=0",
                               busy, cnn_ap_start, res_tdata, frame_cnt);
        end
    endtask

    task automatic test_nominal();
        logic [109:0] r;
        cin_rdy_pct = 100; res_rdy_pct = 100; m_lat = 3;
        for (int k = 0; k < 5; k++) m_word[32*k +: 32] = 32'(k + 1);
        load_frame(0);
        wait_frames(1, 20000);
        r = (q_res.size() > 0) ? q_res[q_res.size()-1] : '0;
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (r[22*k +: 22] !== 22'(k + 1)) begin
                n_fail++; $display("FAIL nominal_slot%0d got=%h exp=%h", k, r[22*k +: 22], k + 1);
            end
        end
        n_tests += 3;
        if (frame_cnt !== 16'd1) begin
            n_fail++; $display("FAIL nominal_frames got=%0d exp=1", frame_cnt);
        end
        if (err_len !== 1'b0) begin
            n_fail++; $display("FAIL nominal_err got=%b exp=0", err_len);
        end
        if (q_fwd_per_frame.size() == 0 || q_fwd_per_frame[q_fwd_per_frame.size()-1] != N) begin
            n_fail++; $display("FAIL nominal_count got=%0d exp=%0d",
                               (q_fwd_per_frame.size() > 0) ? q_fwd_per_frame[q_fwd_per_frame.size()-1] : -1, N);
        end
    endtask

    task automatic test_strip();
        logic [109:0] r;
        int target;
        for (int k = 0; k < 5; k++) m_word[32*k +: 32] = 32'hFFC0_0ABC;
        m_lat = 0;
        target = exp_frames + 1;
        load_frame(1);
        wait_frames(target, 20000);
        r = (q_res.size() > 0) ? q_res[q_res.size()-1] : '0;
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (r[22*k +: 22] !== 22'h000ABC) begin
                n_fail++; $display("FAIL strip_slot%0d got=%h exp=000abc", k, r[22*k +: 22]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int target, base;
        cin_rdy_pct = 50; res_rdy_pct = 50;
        m_lat = $urandom_range(8);
        for (int k = 0; k < 5; k++) m_word[32*k +: 32] = $urandom;
        base   = exp_frames;
        target = base + 3;
        q_fwd_per_frame.delete();
        for (int f = 0; f < 3; f++) load_frame(1);
        wait_frames(target, 40000);
        n_tests += 2;
        if (frame_cnt !== 16'(base + 3)) begin
            n_fail++; $display("FAIL b2b_frames got=%0d exp=%0d", frame_cnt, base + 3);
        end
        if (err_len !== 1'b0) begin
            n_fail++; $display("FAIL b2b_err got=%b exp=0", err_len);
        end
        for (int f = 0; f < q_fwd_per_frame.size(); f++) begin
            n_tests++;
            if (q_fwd_per_frame[f] != N) begin
                n_fail++; $display("FAIL b2b_count%0d got=%0d exp=%0d", f, q_fwd_per_frame[f], N);
            end
        end
        cin_rdy_pct = 100; res_rdy_pct = 100;
    endtask

    task automatic test_idle_gate();
        int target;
        force_busy = 1;
        load_frame(0);
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++;
            if (busy !== 1'b0 || q_src.size() != N) begin
                n_fail++; $display("FAIL idle_gate cyc=%0d got=busy%b/q%0d exp=busy0/q%0d", cyc, busy, q_src.size(), N);
            end
        end
        force_busy = 0;
        target = exp_frames + 1;
        wait_frames(target, 20000);
    endtask

    task automatic test_len_error();
        int target;
        target = exp_frames + 1;
        q_fwd_per_frame.delete();
        load_frame(2);
        wait_frames(target, 20000);
        n_tests += 3;
        if (err_len !== 1'b1) begin
            n_fail++; $display("FAIL len_err got=%b exp=1", err_len);
        end
        if (frame_cnt !== 16'(target)) begin
            n_fail++; $display("FAIL len_frames got=%0d exp=%0d", frame_cnt, target);
        end
        if (q_fwd_per_frame.size() != 1 || q_fwd_per_frame[0] != N) begin
            n_fail++; $display("FAIL len_count got=%0d exp=%0d",
                               (q_fwd_per_frame.size() > 0) ? q_fwd_per_frame[0] : -1, N);
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        load_frame(0);
        while (fwd_cnt < 1000 && c < 5000) begin
            step();
            c++;
        end
        n_tests++;
        if (fwd_cnt != 1000) begin
            n_fail++; $display("FAIL mid_reach got=%0d exp=1000", fwd_cnt);
        end
        do_reset();
        n_tests++;
        if ({pix_in_tready, cnn_ap_start, cnn_in_tvalid, cnn_in_tdata, cnn_out_tready,
             res_tvalid, busy, err_len, timeout} !== 17'd0 ||
            res_tdata !== 110'd0 || frame_cnt !== 16'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs busy=%b start=%b fc=%0d err=%b got nonzero exp=0",
                               busy, cnn_ap_start, frame_cnt, err_len);
        end
        q_fwd_per_frame.delete();
        load_frame(1);
        wait_frames(1, 20000);
        n_tests += 2;
        if (frame_cnt !== 16'd1 || err_len !== 1'b0) begin
            n_fail++; $display("FAIL mid_recover got=fc%0d/err%b exp=fc1/err0", frame_cnt, err_len);
        end
        if (q_fwd_per_frame.size() != 1 || q_fwd_per_frame[0] != N) begin
            n_fail++; $display("FAIL mid_count got=%0d exp=%0d",
                               (q_fwd_per_frame.size() > 0) ? q_fwd_per_frame[0] : -1, N);
        end
    endtask

    task automatic test_timeout();
`ifdef CNN_SEQ_TIMEOUT_EN
        int c = 0;
        int k = 0;
        int frames0;
        frames0  = exp_frames;
        m_no_out = 1;
        load_frame(0);
        while (fwd_cnt < N && c < 20000) begin
            step();
            c++;
        end
        while (timeout !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        n_tests += 3;
        if (k != 100) begin
            n_fail++; $display("FAIL timeout_delay got=%0d exp=100", k);
        end
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_idle got=%b exp=0", busy);
        end
        if (frame_cnt !== 16'(frames0)) begin
            n_fail++; $display("FAIL timeout_frames got=%0d exp=%0d", frame_cnt, frames0);
        end
`else
        int target;
        m_lat  = 150;
        target = exp_frames + 1;
        load_frame(1);
        wait_frames(target, 20000);
        n_tests++;
        if (timeout !== 1'b0 || frame_cnt !== 16'(target)) begin
            n_fail++; $display("FAIL no_watchdog got=to%b/fc%0d exp=to0/fc%0d", timeout, frame_cnt, target);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_strip();
        test_back_to_back();
        test_idle_gate();
        test_len_error();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cnn_frame_sequencer.md
# cnn_frame_sequencer

Controller that sequences one hls4ml CNN inference (`myproject`, ap_ctrl_hs control) per cropped frame. It sits between the crop/normalise stage and the CNN. It gates a pixel stream of exactly `OUT_ROWS*OUT_COLS` Mono8 pixels into the CNN input port and drives `ap_start`. It captures the single 160-bit CNN output word and presents five unpacked 22-bit fixed-point results (ap_fixed<22,11>) on a result stream. It also keeps frame and error status.

## Interface
Parameters:
- `OUT_ROWS`, 48: crop height in pixels.
- `OUT_COLS`, 48: crop width in pixels.
- `TIMEOUT_CYCLES`, 65535: watchdog limit in cycles; only used with `CNN_SEQ_TIMEOUT_EN`.

Ports:
- `ap_clk` in 1: the only clock.
- `ap_rst` in 1: synchronous, active-high reset.
- `pix_in_tdata` in 8: cropped pixel.
- `pix_in_tvalid` in 1: pixel valid.
- `pix_in_tready` out 1: pixel ready.
- `pix_in_tlast` in 1: last pixel of the crop, as marked by upstream.
- `cnn_ap_start` out 1: CNN start.
- `cnn_ap_ready` in 1: CNN ready.
- `cnn_ap_idle` in 1: CNN idle.
- `cnn_ap_done` in 1: CNN done; status only.
- `cnn_in_tdata` out 8, `cnn_in_tvalid` out 1, `cnn_in_tready` in 1: CNN input stream.
- `cnn_out_tdata` in 160, `cnn_out_tvalid` in 1, `cnn_out_tready` out 1: CNN output stream.
- `res_tdata` out 110, `res_tvalid` out 1, `res_tready` in 1: unpacked results.
- `busy` out 1: high whenever the state is not IDLE.
- `frame_cnt` out 16: number of completed frames.
- `err_len` out 1: sticky flag for a tlast/count mismatch.
- `timeout` out 1: sticky watchdog flag.

## Operation
- States: IDLE, STREAM, WAIT_OUT, DELIVER.
- **IDLE**
  - When `pix_in_tvalid & cnn_ap_idle` is sampled high, go to STREAM.
  - Clear the pixel counter `pix_cnt` to 0.
  - Set the start-pending flag.
- **STREAM**
  - `cnn_ap_start` equals the start-pending flag.
  - The flag clears on the first cycle `cnn_ap_ready` is sampled high. It stays clear until the next frame.
  - Pass-through is combinational: `cnn_in_tdata = pix_in_tdata`.
  - `cnn_in_tvalid = pix_in_tvalid`.
  - `pix_in_tready = cnn_in_tready`.
  - Each handshake increments `pix_cnt`.
  - On the handshake with `pix_cnt == N-1` (N = `OUT_ROWS*OUT_COLS`), go to WAIT_OUT.
- **tlast check**
  - `pix_in_tlast` must equal `(pix_cnt == N-1)` on every STREAM handshake.
  - Any mismatch sets `err_len`.
  - The pixel count alone ends the frame. An early tlast does not terminate streaming.
- **WAIT_OUT**
  - `cnn_out_tready = 1`.
  - On handshake, unpack the word into the result register, set `res_tvalid`, and go to DELIVER.
  - Unpack rule: `res_tdata[22k+21:22k] = cnn_out_tdata[32k+21:32k]` for k = 0..4. Bits [32k+31:32k+22] are discarded.
- **DELIVER**
  - Hold `res_tdata` and `res_tvalid`.
  - On the `res_tready` handshake: clear `res_tvalid`, increment `frame_cnt` (16-bit, wraps 0xFFFF→0), and go to IDLE.
- **Gating**
  - Outside STREAM: `pix_in_tready = 0`, `cnn_in_tvalid = 0`, `cnn_ap_start = 0`.
  - Outside WAIT_OUT: `cnn_out_tready = 0`.
  - Frames never overlap; the next frame's pixels are back-pressured until the state returns to IDLE.
- **Reset**
  - At the first edge with `ap_rst` high: state = IDLE and all outputs = 0, including `res_tdata`, `frame_cnt`, `err_len` and `timeout`.
  - The same applies mid-frame. The CNN is reset from the same `ap_rst` at top level.
  - `err_len` and `timeout` clear only on reset.

## Timing
- IDLE→STREAM: `cnn_ap_start` and `pix_in_tready` can first be high 1 cycle after the IDLE condition is sampled.
- Pixel path: 0-cycle latency, no buffering.
- `res_tvalid` rises 1 cycle after the `cnn_out` handshake.
- After the `res` handshake, `busy` falls on the next cycle.
- Minimum frame: 1 + N + 1 + 1 cycles, plus CNN latency.
- If `cnn_ap_ready` and a pixel handshake occur in the same cycle, both take effect.
- `cnn_ap_ready` seen outside STREAM is ignored.

## Configuration
- With `CNN_SEQ_TIMEOUT_EN` defined, a watchdog is compiled in:
  - A 32-bit counter runs in STREAM and WAIT_OUT.
  - It clears on entry to those states and on every pixel or `cnn_out` handshake.
  - When it reaches `TIMEOUT_CYCLES`: `timeout` is set, state goes to IDLE, and the start-pending flag clears. `frame_cnt` does not increment.
- Without the macro: no counter is built, `timeout` is tied to 0, and `TIMEOUT_CYCLES` is ignored.

## Test plan
- **Nominal:** 2304 pixels of value i%256 with tlast on the last, CNN model returning slots 0x00000001..0x00000005 → `cnn_in` sequence identical, `res_tdata` slots = 1..5, `frame_cnt` = 1, `err_len` = 0.
- **Upper-bit stripping:** CNN word with every 32-bit slot = 0xFFC00ABC → each 22-bit result = 0x000ABC.
- **Back-pressure:** random `cnn_in_tready` and `res_tready` at 50% duty, 3 frames → no pixel lost or duplicated, `frame_cnt` = 3, `cnn_ap_start` deasserts one cycle after the first `cnn_ap_ready`.
- **Length error:** tlast on pixel 100 and absent on pixel 2303 → `err_len` = 1, still exactly 2304 pixels forwarded, frame completes.
- **Reset mid-stream:** `ap_rst` asserted at pixel 1000 → next cycle all outputs 0 and `busy` = 0; the next full frame completes normally.
- **Timeout (macro on, `TIMEOUT_CYCLES` = 100):** CNN model never asserts `cnn_out_tvalid` → `timeout` = 1 exactly 100 cycles after the last pixel handshake, state IDLE, `frame_cnt` unchanged.
